switch_debounce_events: RTL and testbench

- Receive end of the board's slide-switch inputs.
- Synchronises and debounces each raw switch line.
- Produces clean levels and one-cycle rise/fall strobes.
- Queues every debounced transition as an {index, level} event on a valid/ready stream for downstream logic (LED/status logic, self-check sequencer).
- Sits directly behind the top-level switch input pins, in the 300 MHz domain.

---
 rtl/switch_debounce_events.sv | 161 ++++++++++++++++
 tb/tb_switch_debounce_events.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_debounce_events.sv
// switch_debounce_events: synchronises and debounces N_IN raw slide-switch lines, drives clean
// levels plus one-cycle rise/fall strobes, and queues every debounced transition as an
// {index, level} event on a valid/ready stream with a sticky lost-event flag.
// Ports: clk, rst_n (synchronous, active-low); in_raw (async raw switches); level/rise/fall;
//        ev_valid/ev_ready/ev_idx/ev_level (event stream); ev_overflow (sticky) / ov_clear.
// Option: define SWITCH_DEBOUNCE_BYPASS_EN to drop the debounce counters (level follows the
//        synchronised input every cycle); ports and parameters are unchanged.
module switch_debounce_events #(
  parameter int N_IN            = 5,
  parameter int DEBOUNCE_CYCLES = 3000000,
  parameter int CNT_W           = 22,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_IN-1:0]         in_raw,
  output logic [N_IN-1:0]         level,
  output logic [N_IN-1:0]         rise,
  output logic [N_IN-1:0]         fall,
  output logic                    ev_valid,
  input  logic                    ev_ready,
  output logic [$clog2(N_IN)-1:0] ev_idx,
  output logic                    ev_level,
  output logic                    ev_overflow,
  input  logic                    ov_clear
);

  localparam int IDX_W  = $clog2(N_IN);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

  // Two-flop synchroniser; sync2_q is the synchronised view of each switch.
  logic [N_IN-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in_raw;
      sync2_q <= sync1_q;
    end
  end

  // toggle[i] marks the cycle in which level[i] flips.
  logic [N_IN-1:0] level_q, level_d, rise_q, fall_q, toggle;

`ifdef SWITCH_DEBOUNCE_BYPASS_EN
  assign toggle = sync2_q ^ level_q;
`else
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_IN-1:0][CNT_W-1:0] cnt_q, cnt_d;

  // Counter runs only while the synchronised input disagrees with the level; any agreeing
  // cycle restarts it, so glitches shorter than DEBOUNCE_CYCLES are absorbed.
  always_comb begin
    cnt_d  = '0;
    toggle = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) toggle[i] = 1'b1;
        else                      cnt_d[i]  = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  assign level_d = level_q ^ toggle;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      level_q <= level_d;
      rise_q  <= toggle & level_d;
      fall_q  <= toggle & ~level_d;
    end
  end

  // Event FIFO state: entries are {idx, level}; count_q separates full from empty.
  logic [IDX_W:0]    mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FCNT_W-1:0] count_q;
  logic              fifo_full, pop, push;

  assign ev_valid  = (count_q != '0);
  assign fifo_full = (count_q == FCNT_W'(FIFO_DEPTH));
  assign pop       = ev_valid && ev_ready;

  // Pending bits: lowest set index is offered to the FIFO each cycle.
  logic [N_IN-1:0]  pend_q, pend_d, push_mask;
  logic [IDX_W-1:0] sel_idx;
  logic             loss;

  always_comb begin
    sel_idx = '0;
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (pend_q[i]) sel_idx = IDX_W'(i);
    end
  end

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push      = (|pend_q) && (!fifo_full || pop);
  assign push_mask = push ? (N_IN'(1) << sel_idx) : '0;

  // A second toggle on a still-pending input cancels the first; that is a lost event.
  // A toggle on the bit being pushed this cycle is a fresh event, not a loss.
  assign loss   = |(toggle & pend_q & ~push_mask);
  assign pend_d = (pend_q & ~push_mask) ^ toggle;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q      <= '0;
      ev_overflow <= 1'b0;
    end else begin
      pend_q <= pend_d;
      // A new loss beats a simultaneous clear.
      if (loss)          ev_overflow <= 1'b1;
      else if (ov_clear) ev_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        // level_q already holds the post-toggle level of the pending input.
        mem_q[wr_ptr_q] <= {sel_idx, level_q[sel_idx]};
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + FCNT_W'(1);
        2'b01:   count_q <= count_q - FCNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  logic [IDX_W:0] head;
  assign head     = mem_q[rd_ptr_q];
  assign ev_idx   = head[IDX_W:1];
  assign ev_level = head[0];

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: tb/tb_switch_debounce_events.sv
module tb_switch_debounce_events;
  localparam int N     = 5;
  localparam int D     = 4;
  localparam int DEPTH = 4;
`ifdef SWITCH_DEBOUNCE_BYPASS_EN
  localparam int MD = 1;
`else
  localparam int MD = D;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] in_raw = '0;
  logic         ev_ready = 1'b0;
  logic         ov_clear = 1'b0;
  logic [N-1:0] level, rise, fall;
  logic         ev_valid, ev_level, ev_overflow;
  logic [2:0]   ev_idx;

  int checks = 0;
  int errors = 0;

  switch_debounce_events #(
    .N_IN(N), .DEBOUNCE_CYCLES(D), .CNT_W(4), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_raw(in_raw), .level(level), .rise(rise), .fall(fall),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_idx(ev_idx), .ev_level(ev_level),
    .ev_overflow(ev_overflow), .ov_clear(ov_clear)
  );

  always #5 clk = ~clk;

  // Reference model. Debounce is expressed as a window rule over the history of synchronised
  // samples: a level flips at edge k when the last MD samples all disagree with it and the
  // window lies entirely after the previous flip (or reset).
  logic [N-1:0] m_s1 = '0, m_s = '0, m_level = '0, m_rise = '0, m_fall = '0, m_pend = '0;
  logic         m_ov = 1'b0;
  logic [N-1:0] s_hist[$];
  int           last_flip[N];
  logic [3:0]   m_fifo[$];

  task automatic model_edge();
    logic pop, push, loss, all_diff;
    int pidx, k;
    logic [N-1:0] tog, nlev, np;
    if (!rst_n) begin
      m_s1 = '0; m_s = '0; m_level = '0; m_rise = '0; m_fall = '0; m_pend = '0; m_ov = 1'b0;
      m_fifo.delete();
      s_hist.delete();
      for (int i = 0; i < N; i++) last_flip[i] = 0;
      return;
    end
    pop  = (m_fifo.size() > 0) && ev_ready;
    pidx = 0;
    for (int i = N - 1; i >= 0; i--) if (m_pend[i]) pidx = i;
    push = (m_pend != '0) && ((m_fifo.size() < DEPTH) || pop);
    s_hist.push_back(m_s);
    k    = s_hist.size();
    tog  = '0;
    nlev = m_level;
    for (int i = 0; i < N; i++) begin
      if (k - last_flip[i] >= MD) begin
        all_diff = 1'b1;
        for (int j = k - MD; j < k; j++) if (s_hist[j][i] == m_level[i]) all_diff = 1'b0;
        if (all_diff) begin
          tog[i] = 1'b1; nlev[i] = ~m_level[i]; last_flip[i] = k;
        end
      end
    end
    np   = m_pend;
    loss = 1'b0;
    if (push) np[pidx] = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (tog[i]) begin
        if (m_pend[i] && !(push && pidx == i)) begin np[i] = 1'b0; loss = 1'b1; end
        else np[i] = 1'b1;
      end
    end
    if (pop)  void'(m_fifo.pop_front());
    if (push) m_fifo.push_back({3'(pidx), m_level[pidx]});
    if (loss) m_ov = 1'b1;
    else if (ov_clear) m_ov = 1'b0;
    m_level = nlev; m_rise = tog & nlev; m_fall = tog & ~nlev; m_pend = np;
    m_s = m_s1; m_s1 = in_raw;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [20:0] dut_obs();
    return {level, rise, fall, ev_valid, (ev_valid ? {ev_idx, ev_level} : 4'b0), ev_overflow};
  endfunction

  function automatic logic [20:0] mdl_obs();
    logic v;
    logic [3:0] hd;
    v  = (m_fifo.size() > 0);
    hd = v ? m_fifo[0] : 4'b0;
    return {m_level, m_rise, m_fall, v, hd, m_ov};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_raw = '0; ev_ready = 1'b0; ov_clear = 1'b0;
    tick(); tick();
    checks++;
    if ({level, rise, fall, ev_valid, ev_idx, ev_level, ev_overflow} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", {level, rise, fall, ev_valid, ev_idx, ev_level, ev_overflow});
    end
    rst_n = 1'b1;
    for (int t = 0; t < 3; t++) begin
      tick();
      checks++;
      if (dut_obs() !== mdl_obs()) begin
        errors++; $display("FAIL reset_idle: dut %h model %h", dut_obs(), mdl_obs());
      end
    end
  endtask

  task automatic test_single_rise();
    int n_lvl = -1, n_vld = -1, n_rise = 0;
    in_raw = 5'b00001; ev_ready = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      checks++;
      if (dut_obs() !== mdl_obs()) begin
        errors++; $display("FAIL single_rise t=%0d: dut %h model %h", t, dut_obs(), mdl_obs());
      end
      if (n_lvl < 0 && level[0]) n_lvl = t;
      if (n_vld < 0 && ev_valid) n_vld = t;
      if (rise[0]) n_rise++;
    end
    checks++;
    if (n_lvl !== MD + 2) begin errors++; $display("FAIL rise_latency: got %0d want %0d", n_lvl, MD + 2); end
    checks++;
    if (n_vld !== MD + 3) begin errors++; $display("FAIL valid_latency: got %0d want %0d", n_vld, MD + 3); end
    checks++;
    if (n_rise !== 1) begin errors++; $display("FAIL rise_pulse_count: got %0d want 1", n_rise); end
  endtask

  task automatic test_glitch();
    logic seen = 1'b0;
    for (int t = 0; t < 15; t++) begin
      in_raw = (t < 3) ? 5'b00101 : 5'b00001;
      tick();
      checks++;
      if (dut_obs() !== mdl_obs()) begin
        errors++; $display("FAIL glitch t=%0d: dut %h model %h", t, dut_obs(), mdl_obs());
      end
      if (level[2] || rise[2] || fall[2] || ev_valid) seen = 1'b1;
    end
`ifndef SWITCH_DEBOUNCE_BYPASS_EN
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL glitch_filtered: activity %b want 0", seen); end
`endif
  endtask

  task automatic test_simultaneous();
    logic [3:0] got[$];
    in_raw = 5'b01011; ev_ready = 1'b1;
    for (int t = 0; t < 20; t++) begin
      if (ev_valid && ev_ready) got.push_back({ev_idx, ev_level});
      tick();
      checks++;
      if (dut_obs() !== mdl_obs()) begin
        errors++; $display("FAIL simultaneous t=%0d: dut %h model %h", t, dut_obs(), mdl_obs());
      end
    end
    checks++;
    if (got.size() !== 2) begin
      errors++; $display("FAIL simul_count: got %0d want 2", got.size());
    end else begin
      checks++;
      if (got[0] !== 4'b0011 || got[1] !== 4'b0111) begin
        errors++; $display("FAIL simul_order: got %h %h want 3 7", got[0], got[1]);
      end
    end
    checks++;
    if (ev_overflow !== 1'b0) begin errors++; $display("FAIL simul_overflow: got %b want 0", ev_overflow); end
  endtask

  task automatic test_overflow();
    int pops = 0;
    logic fell = 1'b0;
    rst_n = 1'b0; in_raw = '0; ev_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    in_raw = 5'b11111;
    for (int t = 0; t < 14; t++) begin
      tick();
      checks++;
      if (dut_obs() !== mdl_obs()) begin
        errors++; $display("FAIL ovf_fill t=%0d: dut %h model %h", t, dut_obs(), mdl_obs());
      end
    end
    in_raw = 5'b01111;
    for (int t = 0; t < 20 && !fell; t++) begin
      tick();
      checks++;
      if (dut_obs() !== mdl_obs()) begin
        errors++; $display("FAIL ovf_drop t=%0d: dut %h model %h", t, dut_obs(), mdl_obs());
      end
      if (!level[4]) fell = 1'b1;
    end
    checks++;
    if (!fell || ev_overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_flag: fell=%b overflow=%b want 1 1", fell, ev_overflow);
    end
    ev_ready = 1'b1;
    for (int t = 0; t < 10; t++) begin
      if (ev_valid) pops++;
      tick();
      checks++;
      if (dut_obs() !== mdl_obs()) begin
        errors++; $display("FAIL ovf_drain t=%0d: dut %h model %h", t, dut_obs(), mdl_obs());
      end
    end
    checks++;
    if (pops !== 4 || ev_valid !== 1'b0) begin
      errors++; $display("FAIL ovf_drain_count: got %0d valid=%b want 4 0", pops, ev_valid);
    end
    ov_clear = 1'b1;
    tick();
    ov_clear = 1'b0;
    checks++;
    if (ev_overflow !== 1'b0) begin errors++; $display("FAIL ov_clear: got %b want 0", ev_overflow); end
  endtask

  task automatic test_reset_mid();
    int n_lvl = -1, n_ev = 0;
    rst_n = 1'b0; in_raw = '0; ev_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick(); tick();
    in_raw = 5'b00001;
    for (int t = 1; t <= 4; t++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({level, rise, fall, ev_valid, ev_idx, ev_level, ev_overflow} !== 22'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %h want 0", {level, rise, fall, ev_valid, ev_idx, ev_level, ev_overflow});
    end
    for (int t = 6; t <= 30; t++) begin
      if (ev_valid && ev_ready) n_ev++;
      tick();
      checks++;
      if (dut_obs() !== mdl_obs()) begin
        errors++; $display("FAIL mid_reset t=%0d: dut %h model %h", t, dut_obs(), mdl_obs());
      end
      if (n_lvl < 0 && level[0]) n_lvl = t;
    end
`ifndef SWITCH_DEBOUNCE_BYPASS_EN
    checks++;
    if (n_lvl !== 11) begin errors++; $display("FAIL mid_reset_latency: got %0d want 11", n_lvl); end
`endif
    checks++;
    if (n_ev !== 1) begin errors++; $display("FAIL mid_reset_events: got %0d want 1", n_ev); end
  endtask

  task automatic test_random();
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 7) == 0) begin
        int b;
        b = $urandom_range(0, N - 1);
        in_raw[b] = ~in_raw[b];
      end
      ev_ready = ($urandom_range(0, 1) == 1);
      ov_clear = ($urandom_range(0, 15) == 0);
      rst_n    = ($urandom_range(0, 299) != 0);
      tick();
      checks++;
      if (dut_obs() !== mdl_obs()) begin
        errors++; $display("FAIL random t=%0d: dut %h model %h", t, dut_obs(), mdl_obs());
      end
    end
    rst_n = 1'b1; ov_clear = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_rise();
    test_glitch();
    test_simultaneous();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
